// File: rtl/pc_pkg.sv
// pc_pkg: operation encoding shared by the program counter and its return stack.
package pc_pkg;
  localparam int PC_OP_W = 3;
  typedef enum logic [PC_OP_W-1:0] {
    PC_INC  = 3'd0,
    PC_BR   = 3'd1,
    PC_JMP  = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4
  } pc_op_t;
endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: LIFO of return addresses; overflowing pushes and underflowing pops are dropped and flagged.
module pc_return_stack #(
  parameter int WIDTH     = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             err
);
  localparam int PW = $clog2(RAS_DEPTH + 1);
  localparam int IW = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             err_q, err_d, do_push, do_pop;
  assign full    = ptr_q == PW'(RAS_DEPTH);
  assign empty   = ptr_q == '0;
  assign err     = err_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem_q[IW'(ptr_q - 1'b1)];
  always_comb begin
    ptr_d = do_push ? ptr_q + 1'b1 : do_pop ? ptr_q - 1'b1 : ptr_q;
    err_d = (push && full) || (pop && empty);
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (clr_n && do_push) mem_q[IW'(ptr_q)] <= din;
  end
endmodule

// File: rtl/program_counter_unit.sv
// program_counter_unit: next-PC mux and PC register; define PC_RAS_EN to build the call/return stack.
module program_counter_unit
  import pc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STEP       = 1,
  parameter int RESET_ADDR = 0,
  parameter int RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             stall,
  input  pc_op_t           op,
  input  logic             cond,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] q,
  output logic             ras_full,
  output logic             ras_empty,
  output logic             ras_err
);
  logic [WIDTH-1:0] q_q, q_d, seq, ret_addr;
  assign seq = q_q + WIDTH'(STEP);
  assign q   = q_q;
`ifdef PC_RAS_EN
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty_w;
  pc_return_stack #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (!stall && op == PC_CALL),
    .pop   (!stall && op == PC_RET),
    .din   (seq),
    .dout  (ras_top),
    .full  (ras_full),
    .empty (ras_empty_w),
    .err   (ras_err)
  );
  assign ras_empty = ras_empty_w;
  assign ret_addr  = ras_empty_w ? seq : ras_top;
`else
  logic unused_depth;
  assign unused_depth = RAS_DEPTH > 0;
  assign ras_full     = 1'b0;
  assign ras_empty    = 1'b1;
  assign ras_err      = 1'b0;
  assign ret_addr     = seq;
`endif
  // Reserved op codes fall through to the sequential increment.
  always_comb begin
    q_d = stall                             ? q_q :
          op == PC_BR                       ? (cond ? q_q + offset : seq) :
          (op == PC_JMP || op == PC_CALL)   ? target :
          op == PC_RET                      ? ret_addr : seq;
  end
  always_ff @(posedge clk) begin
    if (!clr_n) q_q <= WIDTH'(RESET_ADDR);
    else        q_q <= q_d;
  end
endmodule

// File: doc/program_counter_unit.md
# program_counter_unit

Parametrised next-generation program counter for the processor datapath. Holds the current instruction address, advances it by a configurable step, and supports conditional relative branches, absolute jumps, and call/return through an internal return-address stack (RAS). Also supports pipeline stall. Sits between the control unit, which drives the operation and branch condition, and the program memory address port.

## Interface
- WIDTH, 8: address width in bits.
- STEP, 1: sequential increment added to q (use 4 for byte-addressed 32-bit words).
- RESET_ADDR, 0: value loaded into q on clear.
- RAS_DEPTH, 4: return-stack entries, ≥1.

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- clr_n  in  1: synchronous, active-low clear.
- stall  in  1: hold all state this cycle.
- op  in  3: operation, type pc_op_t.
- cond  in  1: branch-taken qualifier, used only by PC_BR.
- offset  in  WIDTH: signed two's-complement branch displacement.
- target  in  WIDTH: absolute jump/call address.
- q  out  WIDTH: current program counter.
- ras_full  out  1: stack holds RAS_DEPTH entries.
- ras_empty  out  1: stack holds 0 entries.
- ras_err  out  1: one-cycle pulse on push-when-full or pop-when-empty.

## Operation
Priority per rising edge: clr_n, then stall, then op.
- **clr_n=0:**
  - q←RESET_ADDR.
  - Stack pointer←0.
  - ras_empty=1, ras_full=0, ras_err=0.
  - Clear wins over stall and any op, including a call or return in the same cycle.
- **stall=1:** q and stack hold; ras_err←0.
- **PC_INC (0):** q←q+STEP.
- **PC_BR (1):** cond=1: q←q+offset; cond=0: q←q+STEP.
- **PC_JMP (2):** q←target.
- **PC_CALL (3):** push q+STEP, then q←target.
  - If the stack is full: the push is dropped, the stack is unchanged, the jump is still taken, and ras_err=1.
- **PC_RET (4):** if the stack is not empty, q←top entry and pop.
  - If the stack is empty: q←q+STEP and ras_err=1.
- **Codes 5–7:** reserved; behave as PC_INC.
- **Arithmetic:** all additions are modulo 2^WIDTH, wrap silently, and have no carry output. STEP is truncated to WIDTH.
- **Stack:** LIFO, with a pointer counting 0..RAS_DEPTH.
  - ras_full = (ptr==RAS_DEPTH).
  - ras_empty = (ptr==0).
- **ras_err:** 0 in every non-error, non-clear cycle.

## Timing
- Every output is registered. Values reflect the state after the most recent rising edge; there is no combinational input→output path.
- Latency is one cycle: a decision at edge N appears on q after edge N.
- A CALL immediately followed by a RET returns to the call address+STEP on the second edge.
- stall may assert or deassert on any cycle. The op presented during a stalled cycle is discarded and is not queued.
- Reset values: q=RESET_ADDR, ras_full=0, ras_empty=1, ras_err=0.
- q is undefined until the first clear. The bench applies clr_n=0 for at least one edge.

## Configuration
- **PC_RAS_EN defined:** the return stack and its flags behave as specified above.
- **PC_RAS_EN undefined:**
  - No stack storage is built.
  - PC_CALL behaves exactly as PC_JMP, with no push.
  - PC_RET behaves as PC_INC.
  - ras_full tied 0, ras_empty tied 1, ras_err tied 0.
  - RAS_DEPTH is ignored.

## Structure
- **Shared package pc_pkg:**
  - pc_op_t: 3-bit enum PC_INC, PC_BR, PC_JMP, PC_CALL, PC_RET.
  - Encoding constants.
- **Sub-module pc_return_stack:**
  - Parameters WIDTH and RAS_DEPTH.
  - Inputs: push, pop, din.
  - Outputs: dout (top), full, empty, err.
  - Synchronous active-low clear.
  - Instantiated only under PC_RAS_EN.
- **Top level:** next-PC selection mux plus the q register.

## Test plan
All scenarios use WIDTH=8, STEP=1, RESET_ADDR=0, RAS_DEPTH=4, with PC_RAS_EN defined unless stated.
- **Clear:** q=0x37 with pending PC_CALL, clr_n=0 for one edge → q=0x00, ras_empty=1, ras_full=0, ras_err=0. Clear with stall=1 gives the same result.
- **Increment wrap:** q=0xFF, PC_INC → q=0x00. Repeat with STEP=4, q=0xFE → q=0x02.
- **Branch:** q=0x10, offset=0xFC, cond=1 → q=0x0C. Then cond=0 → q=0x0D. Then q=0xF0, offset=0x20, cond=1 → q=0x10.
- **Call/return:**
  - q=0x20, PC_CALL target=0x80 → q=0x80, ras_empty=0.
  - Then PC_RET → q=0x21, ras_empty=1.
  - Nested calls from 0x20→0x80→0x90 followed by two RETs → q=0x81, then q=0x21.
- **Overflow/underflow:**
  - Four CALLs → ras_full=1.
  - Fifth CALL target=0x40 → q=0x40, ras_err=1 for exactly one cycle.
  - Four RETs → return addresses come back in LIFO order.
  - Fifth RET with q=0x50 → q=0x51, ras_err=1.
- **Stall and macro off:**
  - stall=1 with PC_JMP target=0x55 → q and stack unchanged for every stalled cycle.
  - With PC_RAS_EN undefined, PC_CALL target=0x80 → q=0x80, ras_empty=1. Then PC_RET → q=0x81, ras_err=0.
